instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] are 0).
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble inserted into IF/ID.
REQ-003 Reset reset_n, synchronous, active-low; clock clk.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 if_stall_i  input  1  hold the IF/ID registers and the PC.
REQ-007 if_flush_i  input  1  replace IF/ID contents with a bubble.
REQ-008 branch_taken_i  input  1  redirect fetch from EX.
REQ-009 branch_target_i  input  32  redirect address.
REQ-010 imem_req_o  output  1  instruction memory request.
REQ-011 imem_addr_o  output  32  request address, word aligned.
REQ-012 imem_gnt_i  input  1  request accepted this cycle.
REQ-013 imem_rvalid_i  input  1  read data valid.
REQ-014 imem_rdata_i  input  32  instruction word.
REQ-015 PIP_instr_o  output  32  IF/ID instruction register to decode.
REQ-016 PIP_pc_o  output  32  IF/ID PC register to decode.
REQ-017 PIP_valid_o  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-018 The block SHALL keep PC register pc_q and an FSM with states FETCH, WAIT, HOLD, DISCARD, with at most one memory request outstanding.
REQ-019 FETCH: imem_req_o=1 and imem_addr_o=pc_q, held stable until imem_gnt_i; on gnt go to WAIT.
REQ-020 WAIT/HOLD/DISCARD: imem_req_o=0; imem_addr_o SHALL remain pc_q.
REQ-021 WAIT with imem_rvalid_i and !if_stall_i: IF/ID <= {imem_rdata_i, pc_q, valid=1}; pc_q <= pc_q+4; go to FETCH (minimum 2 cycles per instruction with 0-wait memory).
REQ-022 WAIT with imem_rvalid_i and if_stall_i: capture rdata into skid register; IF/ID held; go to HOLD.
REQ-023 HOLD with !if_stall_i: IF/ID <= {skid, pc_q, valid=1}; pc_q <= pc_q+4; go to FETCH.
REQ-024 DISCARD: on imem_rvalid_i drop data, go to FETCH; IF/ID unaffected.
REQ-025 if_stall_i SHALL hold IF/ID and pc_q but SHALL NOT block an already-issued FETCH request or its grant.
REQ-026 branch_taken_i (priority over stall and flush) SHALL set pc_q <= {branch_target_i[31:2],2'b00}, load IF/ID with {NOP_INSTR, 0, 0}, drop any skid data.
REQ-027 Redirect next state: DISCARD if in WAIT without rvalid this cycle, or in FETCH with gnt this cycle; otherwise FETCH.
REQ-028 if_flush_i without redirect (priority over stall): IF/ID <= {NOP_INSTR, 0, 0}; a response arriving that cycle or held in HOLD SHALL be dropped, pc_q unchanged, next state FETCH (same PC re-fetched); in FETCH/DISCARD the state is unaffected.
REQ-029 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-030 imem_rvalid_i in FETCH SHALL be ignored.

Reset
REQ-031 While reset_n=0 at a clock edge: pc_q=RESET_PC, state=FETCH, skid cleared, PIP_instr_o=NOP_INSTR, PIP_pc_o=0, PIP_valid_o=0.
REQ-032 imem_req_o SHALL be 0 in any cycle where reset_n=0; reset mid-transaction SHALL abandon the outstanding request and a late rvalid arriving after reset SHALL be ignored until the first post-reset grant (FETCH state).

Verification
REQ-033 Reset, memory gnt same cycle, rvalid next cycle, rdata 0x00500093 -> first fetch addr 0x0, IF/ID={0x00500093,0x0,1}, next request addr 0x4.
REQ-034 if_stall_i high for 3 cycles while rvalid arrives at PC 0x8 -> HOLD entered, IF/ID unchanged, released instruction appears with PC 0x8 one edge after stall drops, next addr 0xC.
REQ-035 branch_taken_i with target 0x103 while in WAIT at PC 0x20 -> IF/ID bubble, DISCARD, stale rdata dropped, next request addr 0x100.
REQ-036 if_flush_i alone coinciding with rvalid at PC 0x40 -> IF/ID bubble, valid=0, next request re-fetches 0x40.
REQ-037 RESET_PC=0xFFFFFFFC -> first instruction PC 0xFFFFFFFC, second request addr 0x00000000.
REQ-038 gnt held low 5 cycles -> imem_req_o=1 and imem_addr_o constant throughout; stall/no-stall yields identical address sequence.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with one outstanding imem request, stall skid and redirect/flush handling
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PIP_instr_o,
    output logic [31:0] PIP_pc_o,
    output logic        PIP_valid_o
);
    localparam logic [1:0] FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DISCARD = 2'd3;
    logic [1:0]  state;
    logic [31:0] pc_q, skid;
    assign imem_req_o  = reset_n && state == FETCH;
    assign imem_addr_o = pc_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            state       <= FETCH;
            skid        <= '0;
            PIP_instr_o <= NOP_INSTR;
            PIP_pc_o    <= '0;
            PIP_valid_o <= 1'b0;
        end else if (branch_taken_i) begin
            pc_q        <= branch_target_i & ~32'd3;
            skid        <= '0;
            PIP_instr_o <= NOP_INSTR;
            PIP_pc_o    <= '0;
            PIP_valid_o <= 1'b0;
            // a response still owed by memory must be swallowed before refetching
            state <= ((state == WAIT && !imem_rvalid_i) || (state == FETCH && imem_gnt_i)) ? DISCARD : FETCH;
        end else begin
            case (state)
                FETCH: if (imem_gnt_i) state <= WAIT;
                WAIT: if (imem_rvalid_i) begin
                    if (if_flush_i) state <= FETCH;
                    else if (!if_stall_i) begin
                        PIP_instr_o <= imem_rdata_i;
                        PIP_pc_o    <= pc_q;
                        PIP_valid_o <= 1'b1;
                        pc_q        <= pc_q + 32'd4;
                        state       <= FETCH;
                    end else begin
                        skid  <= imem_rdata_i;
                        state <= HOLD;
                    end
                end
                HOLD: if (if_flush_i) state <= FETCH;
                else if (!if_stall_i) begin
                    PIP_instr_o <= skid;
                    PIP_pc_o    <= pc_q;
                    PIP_valid_o <= 1'b1;
                    pc_q        <= pc_q + 32'd4;
                    state       <= FETCH;
                end
                default: if (imem_rvalid_i) state <= FETCH;
            endcase
            if (if_flush_i) begin
                PIP_instr_o <= NOP_INSTR;
                PIP_pc_o    <= '0;
                PIP_valid_o <= 1'b0;
            end
        end
    end
endmodule
